life_control: RTL
=================

# life_control

Sequencing controller for the Game of Life grid datapath. Converts user key requests and a generation timer into the datapath's one-hot command strobes (ld_x, ld_y, update_single, update_temp, update_grid, drw) and sweeps the cell index over the 8x8 grid. It also emits the VGA adapter's plot strobe, aligned to the datapath's registered x/y/colour outputs.

## Interface

Parameters:
- CELLS, 64, number of grid cells; the index sweeps 0..CELLS-1
- TICK_CYCLES, 25000000, clk cycles per automatic generation while run=1

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- req_ld_x  in  1  level; a rising edge requests a load of the cursor x from switches
- req_ld_y  in  1  level; a rising edge requests a load of the cursor y
- req_toggle  in  1  level; a rising edge requests a toggle of the cursor cell
- req_step  in  1  level; a rising edge requests one generation
- run  in  1  level; 1 enables automatic generations
- ld_x, ld_y, update_single  out  1  one-cycle datapath strobes
- update_temp, update_grid, drw  out  1  datapath sweep strobes
- xy_position  out  7  {1'b0, cell index[5:0]}
- plot  out  1  VGA write enable
- busy  out  1  1 when state != IDLE
- gen_count  out  8  completed generations, modulo 256

## Operation

- Edge detect: a 1-bit previous-value register per req_*. Input high at edge k after low at edge k-1 sets that request's pending flag at edge k.
- Pending flags: p_x, p_y, p_tog, p_gen, p_draw. Each flag saturates at 1, so repeated requests coalesce. A flag clears on the edge where its service state is entered.
- Tick counter: 25-bit.
  - Cleared while run=0.
  - Otherwise increments; at TICK_CYCLES-1 it wraps to 0 and sets p_gen.
  - Counts regardless of FSM state.
- FSM states: IDLE, LDX, LDY, TOG, COMPUTE, COMMIT, DRAW, DRAW_TAIL.
- IDLE priority: p_x -> LDX, else p_y -> LDY, else p_tog -> TOG, else p_draw -> DRAW, else p_gen -> COMPUTE.
- LDX, LDY: one cycle each with ld_x / ld_y = 1, then IDLE.
- TOG: one cycle with update_single = 1, then DRAW.
- COMPUTE:
  - CELLS cycles, update_temp = 1, index 0..CELLS-1.
  - After index CELLS-1, index -> 0 and state -> COMMIT.
- COMMIT:
  - CELLS cycles, update_grid = 1, index 0..CELLS-1.
  - gen_count increments (wrapping 255->0) on the edge leaving COMMIT; state -> DRAW.
- DRAW: CELLS cycles, drw = 1, index 0..CELLS-1, then DRAW_TAIL.
- DRAW_TAIL: one cycle with drw = 0, then IDLE.
- plot = drw registered one cycle. Every drawn cell gets exactly one plot, in the cycle after its drw, when the datapath's x/y/colour are valid.
- Strobes are mutually exclusive. In IDLE all strobes are 0, and the index holds its last value.
- Requests arriving in a non-IDLE state are latched and serviced after return to IDLE. An in-progress sweep is never aborted or reordered.
- Reset (in any state, including mid-sweep):
  - state = IDLE, index = 0, gen_count = 0, tick counter = 0.
  - All strobes, plot and busy = 0.
  - p_x/p_y/p_tog/p_gen = 0; p_draw = 1, so one full redraw runs after reset.
  - Edge-detect registers load 1, so keys held high through reset do not fire.

## Timing

- Edit latency: request edge k -> service state entered at k+1 (if IDLE at k) -> strobe high for cycle k+1..k+2 -> IDLE at k+2.
- Generation: IDLE decision at edge t.
  - COMPUTE occupies t+1..t+CELLS.
  - COMMIT occupies t+CELLS+1..t+2·CELLS.
  - DRAW occupies t+2·CELLS+1..t+3·CELLS.
  - DRAW_TAIL at t+3·CELLS+1; IDLE at t+3·CELLS+2.
  - For CELLS=64 that is 194 cycles edge to IDLE.
- Toggle: 1 + CELLS + 1 cycles in non-IDLE states (66 for CELLS=64).
- busy is high exactly for non-IDLE states and is registered with the state.

## Test plan

- Reset release: with all req_* low, a redraw starts on the first clock after release. Exactly 64 plot pulses follow, with xy_position 0..63 on the corresponding drw cycles, and the first plot appears one cycle after the first drw. busy then drops and gen_count = 0.
- req_ld_x rises while IDLE: ld_x is high for exactly 1 cycle, 2 edges after the rise, and no other strobe fires. Holding req_ld_x high for 10 cycles still yields 1 pulse.
- req_step pulse: update_temp for 64 cycles (index 0..63), then update_grid for 64 cycles, then drw for 64 cycles. gen_count goes 0->1 and busy is high for 193 cycles.
- run=1 with TICK_CYCLES=300: generations start every 300 cycles. A tick arriving while busy runs right after the current sweep finishes. After 256 generations gen_count wraps to 0.
- req_ld_x, req_ld_y and req_toggle rise on the same cycle: the service order is ld_x, then ld_y, then update_single, then a 64-cell redraw, with one pulse each.
- Reset asserted at COMPUTE index 30: all outputs are 0 on the next edge. After release, a redraw runs (with no COMMIT) and gen_count = 0.

Source files
------------

// File: rtl/life_control_if.sv
// Request and command bundle between the key/timer side and the life_control sequencer.
// The master drives the key requests and run; the slave (the sequencer) drives the strobes.
interface life_control_if;
    logic       req_ld_x;
    logic       req_ld_y;
    logic       req_toggle;
    logic       req_step;
    logic       run;

    logic       ld_x;
    logic       ld_y;
    logic       update_single;
    logic       update_temp;
    logic       update_grid;
    logic       drw;
    logic [6:0] xy_position;
    logic       plot;
    logic       busy;
    logic [7:0] gen_count;

    modport master (
        output req_ld_x, req_ld_y, req_toggle, req_step, run,
        input  ld_x, ld_y, update_single, update_temp, update_grid, drw,
        input  xy_position, plot, busy, gen_count
    );

    modport slave (
        input  req_ld_x, req_ld_y, req_toggle, req_step, run,
        output ld_x, ld_y, update_single, update_temp, update_grid, drw,
        output xy_position, plot, busy, gen_count
    );
endinterface

// File: rtl/life_control.sv
// Game of Life sequencer: turns key edges and a generation timer into one-hot
// datapath strobes, sweeps the cell index, and emits the VGA plot strobe.
module life_control #(
    parameter int CELLS       = 64,
    parameter int TICK_CYCLES = 25000000
) (
    input  logic           clk,
    input  logic           resetn,
    life_control_if.slave  bus
);

    localparam int IDX_W  = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int TICK_W = 25;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CELLS - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LDX,
        LDY,
        TOG,
        COMPUTE,
        COMMIT,
        DRAW,
        DRAW_TAIL
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  index_q;
    logic [7:0]        gen_count_q;
    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;
    logic              tick_wrap;

    // Request bit order: {step, toggle, ld_y, ld_x}
    logic [3:0] req_vec;
    logic [3:0] req_prev_q;
    logic [3:0] req_rise;
    logic       gen_set;

    logic p_x_q;
    logic p_y_q;
    logic p_tog_q;
    logic p_gen_q;
    logic p_draw_q;

    logic ld_x_q;
    logic ld_y_q;
    logic update_single_q;
    logic update_temp_q;
    logic update_grid_q;
    logic drw_q;
    logic plot_q;
    logic busy_q;

    assign req_vec  = {bus.req_step, bus.req_toggle, bus.req_ld_y, bus.req_ld_x};
    assign req_rise = req_vec & ~req_prev_q;

    // Previous-value registers load 1 in reset so keys held through reset stay quiet.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            req_prev_q <= 4'b1111;
        end else begin
            req_prev_q <= req_vec;
        end
    end

    always_comb begin
        tick_wrap = bus.run && (tick_q == TICK_LAST);
        tick_d    = '0;
        if (bus.run && !tick_wrap) begin
            tick_d = tick_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign gen_set = req_rise[3] | tick_wrap;

    // Pending flags are folded into the FSM so a clear and a fresh request on the
    // same edge resolve in one place: the fresh request survives.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= IDLE;
            index_q         <= '0;
            gen_count_q     <= '0;
            p_x_q           <= 1'b0;
            p_y_q           <= 1'b0;
            p_tog_q         <= 1'b0;
            p_gen_q         <= 1'b0;
            p_draw_q        <= 1'b1;
            ld_x_q          <= 1'b0;
            ld_y_q          <= 1'b0;
            update_single_q <= 1'b0;
            update_temp_q   <= 1'b0;
            update_grid_q   <= 1'b0;
            drw_q           <= 1'b0;
            plot_q          <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            ld_x_q          <= 1'b0;
            ld_y_q          <= 1'b0;
            update_single_q <= 1'b0;
            update_temp_q   <= 1'b0;
            update_grid_q   <= 1'b0;
            drw_q           <= 1'b0;
            plot_q          <= drw_q;

            p_x_q   <= p_x_q   | req_rise[0];
            p_y_q   <= p_y_q   | req_rise[1];
            p_tog_q <= p_tog_q | req_rise[2];
            p_gen_q <= p_gen_q | gen_set;

            case (state_q)
                IDLE: begin
                    if (p_x_q) begin
                        state_q <= LDX;
                        ld_x_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        p_x_q   <= req_rise[0];
                    end else if (p_y_q) begin
                        state_q <= LDY;
                        ld_y_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        p_y_q   <= req_rise[1];
                    end else if (p_tog_q) begin
                        state_q         <= TOG;
                        update_single_q <= 1'b1;
                        busy_q          <= 1'b1;
                        p_tog_q         <= req_rise[2];
                    end else if (p_draw_q) begin
                        state_q  <= DRAW;
                        drw_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        index_q  <= '0;
                        p_draw_q <= 1'b0;
                    end else if (p_gen_q) begin
                        state_q       <= COMPUTE;
                        update_temp_q <= 1'b1;
                        busy_q        <= 1'b1;
                        index_q       <= '0;
                        p_gen_q       <= gen_set;
                    end
                end
                LDX, LDY: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                TOG: begin
                    state_q <= DRAW;
                    drw_q   <= 1'b1;
                    index_q <= '0;
                end
                COMPUTE: begin
                    if (index_q == LAST_IDX) begin
                        state_q       <= COMMIT;
                        index_q       <= '0;
                        update_grid_q <= 1'b1;
                    end else begin
                        index_q       <= index_q + 1'b1;
                        update_temp_q <= 1'b1;
                    end
                end
                COMMIT: begin
                    if (index_q == LAST_IDX) begin
                        state_q     <= DRAW;
                        index_q     <= '0;
                        drw_q       <= 1'b1;
                        gen_count_q <= gen_count_q + 8'd1;
                    end else begin
                        index_q       <= index_q + 1'b1;
                        update_grid_q <= 1'b1;
                    end
                end
                DRAW: begin
                    if (index_q == LAST_IDX) begin
                        // Index holds on the last cell; the tail only lets plot catch up.
                        state_q <= DRAW_TAIL;
                    end else begin
                        index_q <= index_q + 1'b1;
                        drw_q   <= 1'b1;
                    end
                end
                DRAW_TAIL: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ld_x          = ld_x_q;
    assign bus.ld_y          = ld_y_q;
    assign bus.update_single = update_single_q;
    assign bus.update_temp   = update_temp_q;
    assign bus.update_grid   = update_grid_q;
    assign bus.drw           = drw_q;
    assign bus.xy_position   = 7'(index_q);
    assign bus.plot          = plot_q;
    assign bus.busy          = busy_q;
    assign bus.gen_count     = gen_count_q;

endmodule
